// File: rtl/scl_tick_generator.sv
// -----------------------------------------------------------------------------
// scl_tick_generator
//
// Generates an I2C-style SCL waveform from a runtime half-period divisor,
// together with single-cycle phase strobes (falling edge, rising edge, middle
// of the low phase, middle of the high phase).
//
// Optional clock stretching: after releasing SCL, the generator waits in
// WAIT_HIGH until the synchronised bus level reads high. A non-zero
// STRETCH_LIMIT bounds that wait. On expiry the generator raises a sticky
// timeout flag and parks in IDLE.
//
// This block has no valid/ready handshake. enable is a level request: while
// high the clock runs, and when sampled low the block returns to IDLE on the
// next cycle from any state.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   enable         run request (1 = generate SCL, 0 = go idle)
//   divisor        half-period length in clk cycles (values below 2 act as 2)
//   stretch_en     1 = honour target clock stretching
//   scl_in         sensed SCL bus level, asynchronous to clk
//   scl_out        SCL drive level (1 = release/high, 0 = drive low)
//   tick_fall      strobe on the first cycle of each low phase
//   tick_rise      strobe on the cycle SCL is released
//   tick_mid_low   strobe in the middle of the low phase
//   tick_mid_high  strobe in the middle of the high phase
//   stretching     high while waiting for the bus to go high
//   timeout        sticky stretch-timeout flag, cleared by dropping enable
//   dbg_state      current FSM state, for observation only
// -----------------------------------------------------------------------------
module scl_tick_generator #(
  parameter int DIV_WIDTH     = 16,
  parameter int STRETCH_LIMIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 stretch_en,
  input  logic                 scl_in,
  output logic                 scl_out,
  output logic                 tick_fall,
  output logic                 tick_rise,
  output logic                 tick_mid_low,
  output logic                 tick_mid_high,
  output logic                 stretching,
  output logic                 timeout,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOW       = 2'd1,
    S_WAIT_HIGH = 2'd2,
    S_HIGH      = 2'd3
  } state_e;

  // The wait counter only needs to reach STRETCH_LIMIT-1. It saturates
  // rather than wraps, so with no limit it simply parks at all-ones.
  localparam int WW = (STRETCH_LIMIT > 0) ? $clog2(STRETCH_LIMIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((STRETCH_LIMIT > 0) ? STRETCH_LIMIT - 1 : 0);
  localparam logic [WW-1:0] WAIT_MAX  = '1;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 scl_q, scl_d;
  logic                 fall_q, fall_d;
  logic                 rise_q, rise_d;
  logic                 mid_low_q, mid_low_d;
  logic                 mid_high_q, mid_high_d;
  logic                 timeout_q, timeout_d;
  logic                 sync1_q, sync2_q;

  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] cnt_last;
  logic [DIV_WIDTH-1:0] cnt_half_m1;

  // A divisor of 0 or 1 behaves as 2. This guarantees the four strobes of a
  // period always land on distinct cycles.
  assign div_eff     = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;
  assign cnt_last    = div_q - DIV_WIDTH'(1);
  // A mid strobe is registered one cycle early, so that it appears on the
  // cycle where the phase counter equals div_q/2.
  assign cnt_half_m1 = (div_q >> 1) - DIV_WIDTH'(1);

  // Two-flop synchroniser. It resets to 1 (bus released), so a fresh start
  // never sees a phantom low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= scl_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_WIDTH'(2);
      wait_q     <= '0;
      scl_q      <= 1'b1;
      fall_q     <= 1'b0;
      rise_q     <= 1'b0;
      mid_low_q  <= 1'b0;
      mid_high_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      wait_q     <= wait_d;
      scl_q      <= scl_d;
      fall_q     <= fall_d;
      rise_q     <= rise_d;
      mid_low_q  <= mid_low_d;
      mid_high_q <= mid_high_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    wait_d     = wait_q;
    scl_d      = scl_q;
    fall_d     = 1'b0;
    rise_d     = 1'b0;
    mid_low_d  = 1'b0;
    mid_high_d = 1'b0;
    timeout_d  = timeout_q;

    if (!enable) begin
      // Dropping enable wins over every phase-end and timeout event, and it
      // is also the only way to clear a timeout.
      state_d   = S_IDLE;
      cnt_d     = '0;
      wait_d    = '0;
      scl_d     = 1'b1;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!timeout_q) begin
            state_d = S_LOW;
            cnt_d   = '0;
            div_d   = div_eff;
            scl_d   = 1'b0;
            fall_d  = 1'b1;
          end
        end
        S_LOW: begin
          if (cnt_q == cnt_last) begin
            scl_d  = 1'b1;
            rise_d = 1'b1;
            cnt_d  = '0;
            if (stretch_en) begin
              state_d = S_WAIT_HIGH;
              wait_d  = '0;
            end else begin
              state_d = S_HIGH;
              div_d   = div_eff;
            end
          end else begin
            cnt_d     = cnt_q + DIV_WIDTH'(1);
            mid_low_d = (cnt_q == cnt_half_m1);
          end
        end
        S_WAIT_HIGH: begin
          if (sync2_q) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            div_d   = div_eff;
          end else if ((STRETCH_LIMIT > 0) && (wait_q == WAIT_LAST)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            scl_d     = 1'b1;
            timeout_d = 1'b1;
          end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_HIGH: begin
          if (cnt_q == cnt_last) begin
            state_d = S_LOW;
            cnt_d   = '0;
            div_d   = div_eff;
            scl_d   = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d      = cnt_q + DIV_WIDTH'(1);
            mid_high_d = (cnt_q == cnt_half_m1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign scl_out       = scl_q;
  assign tick_fall     = fall_q;
  assign tick_rise     = rise_q;
  assign tick_mid_low  = mid_low_q;
  assign tick_mid_high = mid_high_q;
  assign stretching    = (state_q == S_WAIT_HIGH);
  assign timeout       = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_scl_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_scl_tick_generator
//
// Testbench for scl_tick_generator, built with DIV_WIDTH=16 and
// STRETCH_LIMIT=50.
//
// Inputs change 2 ns after each rising clock edge. Outputs are observed on
// the falling edge. A behavioural model tracks which phase the clock is in,
// how far into that phase it is, and how long that phase lasts. Every cycle
// the model pushes its predicted output vector into exp_q, and the vector is
// compared against the DUT one cycle later.
//
// Directed sections check absolute strobe positions against the expected
// timing. A long randomized section then drives divisor, enable,
// stretch_en and a stretching target.
// -----------------------------------------------------------------------------
module tb_scl_tick_generator;

  localparam int DW    = 16;
  localparam int LIMIT = 50;
  localparam int VW    = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          enable;
  logic [DW-1:0] divisor;
  logic          stretch_en;
  logic          scl_in;
  logic          scl_out, tick_fall, tick_rise, tick_mid_low, tick_mid_high;
  logic          stretching, timeout;
  logic [1:0]    dbg_state;

  scl_tick_generator #(.DIV_WIDTH(DW), .STRETCH_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .divisor      (divisor),
    .stretch_en   (stretch_en),
    .scl_in       (scl_in),
    .scl_out      (scl_out),
    .tick_fall    (tick_fall),
    .tick_rise    (tick_rise),
    .tick_mid_low (tick_mid_low),
    .tick_mid_high(tick_mid_high),
    .stretching   (stretching),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // Output vector order: {scl_out, fall, rise, mid_low, mid_high, stretching, timeout}
  logic [VW-1:0] obs_vec;
  assign obs_vec = {scl_out, tick_fall, tick_rise, tick_mid_low, tick_mid_high, stretching, timeout};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // m_mode: 0 idle, 1 low, 2 waiting for bus high, 3 high.
  // m_pos is the 0-based cycle index inside the current phase.
  int            m_mode, m_pos, m_len, m_waited;
  logic          m_scl, m_fall, m_rise, m_ml, m_mh, m_to;
  logic          m_h1, m_h2;   // scl_in one and two cycles ago
  logic [VW-1:0] exp_q[$];

  function automatic int eff_div(input logic [DW-1:0] d);
    return (int'(d) < 2) ? 2 : int'(d);
  endfunction

  // Applies the next rising edge, using the inputs currently applied.
  task model_step();
    m_fall = 1'b0; m_rise = 1'b0; m_ml = 1'b0; m_mh = 1'b0;
    if (!enable) begin
      m_mode = 0; m_scl = 1'b1; m_to = 1'b0;
    end else if (m_mode == 0) begin
      if (!m_to) begin
        m_mode = 1; m_len = eff_div(divisor); m_pos = 0; m_scl = 1'b0; m_fall = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (m_pos == m_len - 1) begin
        m_scl = 1'b1; m_rise = 1'b1;
        if (stretch_en) begin
          m_mode = 2; m_waited = 1;
        end else begin
          m_mode = 3; m_len = eff_div(divisor); m_pos = 0;
        end
      end else begin
        m_pos++;
        m_ml = (m_pos == m_len / 2);
      end
    end else if (m_mode == 2) begin
      // The decision uses the bus level seen through two flops of delay.
      if (m_h2) begin
        m_mode = 3; m_len = eff_div(divisor); m_pos = 0;
      end else if (m_waited == LIMIT) begin
        m_mode = 0; m_to = 1'b1; m_scl = 1'b1;
      end else begin
        m_waited++;
      end
    end else begin
      if (m_pos == m_len - 1) begin
        m_mode = 1; m_len = eff_div(divisor); m_pos = 0; m_scl = 1'b0; m_fall = 1'b1;
      end else begin
        m_pos++;
        m_mh = (m_pos == m_len / 2);
      end
    end
    m_h2 = m_h1;
    m_h1 = scl_in;
  endtask

  always @(negedge clk) begin : scoreboard
    logic [VW-1:0] e;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_len = 2; m_waited = 0; m_to = 1'b0; m_scl = 1'b1;
      m_fall = 1'b0; m_rise = 1'b0; m_ml = 1'b0; m_mh = 1'b0;
      m_h1 = 1'b1; m_h2 = 1'b1;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("outputs", 32'(obs_vec), 32'(e));
      end
      model_step();
      exp_q.push_back({m_scl, m_fall, m_rise, m_ml, m_mh, (m_mode == 2), m_to});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    next_cyc();
    enable = 1'b0;
    next_cyc();
    next_cyc();
  endtask

  task automatic wait_rise(input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick_rise) begin
        found = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(found), 32'd1);
  endtask

  // Expected {scl, fall, rise, mid_low, mid_high} at cycle offset off after
  // enable is applied from idle, with stretching off.
  function automatic logic [4:0] exp_simple(input int off, input int e);
    logic s, f, r, ml, mh;
    s  = (off == 0) || (off > e && off <= 2 * e);
    f  = (off == 1) || (off == 2 * e + 1);
    ml = (off == 1 + e / 2);
    r  = (off == 1 + e);
    mh = (off == 1 + e + e / 2);
    return {s, f, r, ml, mh};
  endfunction

  task automatic run_simple(input int d);
    int e = (d < 2) ? 2 : d;
    go_idle();
    stretch_en = 1'b0;
    scl_in     = 1'b1;
    divisor    = DW'(d);
    enable     = 1'b1;
    for (int off = 0; off <= 2 * e + 1; off++) begin
      @(negedge clk);
      check_val($sformatf("period_d%0d_off%0d", d, off),
                32'({scl_out, tick_fall, tick_rise, tick_mid_low, tick_mid_high}),
                32'(exp_simple(off, e)));
    end
  endtask

  // ---------------- main sequence ----------------
  int hold;

  initial begin
    rst_n = 1'b0; enable = 1'b0; divisor = 16'd10; stretch_en = 1'b0; scl_in = 1'b1;
    hold = 0;
    repeat (2) @(negedge clk);
    check_val("reset_state", 32'(obs_vec), 32'(7'b1000000));

    // After reset, the generator stays idle until enable is seen high.
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_hold", 32'(obs_vec), 32'(7'b1000000));
    end

    // Nominal period, plus divisors clamped to 2.
    run_simple(10);
    run_simple(0);
    run_simple(1);
    run_simple(2);
    run_simple(7);

    // Target holds SCL low for 30 cycles after the release.
    go_idle();
    stretch_en = 1'b1; scl_in = 1'b0; divisor = 16'd6; enable = 1'b1;
    wait_rise(20, "stretch_rise_seen");
    check_val("stretch_at_rise", 32'({scl_out, stretching}), 32'(2'b11));
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      check_val("stretch_hold", 32'({scl_out, stretching}), 32'(2'b11));
    end
    next_cyc();
    scl_in = 1'b1;
    for (int off = 0; off <= 9; off++) begin
      logic [3:0] ev;
      @(negedge clk);
      if (off <= 2)       ev = 4'b1001;
      else if (off == 6)  ev = 4'b1010;
      else if (off == 9)  ev = 4'b0100;
      else                ev = 4'b1000;
      check_val($sformatf("stretch_release_off%0d", off),
                32'({scl_out, tick_fall, tick_mid_high, stretching}), 32'(ev));
    end

    // SCL stuck low: timeout after LIMIT waiting cycles.
    go_idle();
    stretch_en = 1'b1; scl_in = 1'b0; divisor = 16'd4; enable = 1'b1;
    wait_rise(20, "timeout_rise_seen");
    for (int k = 1; k < LIMIT; k++) begin
      @(negedge clk);
      check_val("timeout_waiting", 32'({stretching, timeout}), 32'(2'b10));
    end
    @(negedge clk);
    check_val("timeout_set", 32'(obs_vec), 32'(7'b1000001));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("timeout_no_restart", 32'({scl_out, tick_fall, timeout}), 32'(3'b101));
    end
    next_cyc();
    enable = 1'b0;
    @(negedge clk);
    check_val("timeout_until_sampled", 32'(timeout), 32'd1);
    next_cyc();
    enable = 1'b1; scl_in = 1'b1;
    @(negedge clk);
    check_val("timeout_cleared", 32'({timeout, tick_fall}), 32'(2'b00));
    @(negedge clk);
    check_val("restart_after_timeout", 32'({scl_out, tick_fall}), 32'(2'b01));

    // Divisor change mid-LOW takes effect at the next phase; enable drop mid-HIGH.
    go_idle();
    stretch_en = 1'b0; scl_in = 1'b1; divisor = 16'd10; enable = 1'b1;
    for (int off = 0; off <= 23; off++) begin
      logic [4:0] ev;
      if (off == 4)  divisor = 16'd4;
      if (off == 20) enable  = 1'b0;
      @(negedge clk);
      ev[4] = !((off >= 1 && off <= 10) || (off >= 15 && off <= 18));
      ev[3] = (off == 1) || (off == 15);
      ev[2] = (off == 11) || (off == 19);
      ev[1] = (off == 6) || (off == 17);
      ev[0] = (off == 13);
      check_val($sformatf("divchg_off%0d", off),
                32'({scl_out, tick_fall, tick_rise, tick_mid_low, tick_mid_high}), 32'(ev));
      next_cyc();
    end

    // Reset asserted mid-LOW, between clock edges.
    go_idle();
    divisor = 16'd10; enable = 1'b1;
    repeat (4) @(negedge clk);
    check_val("pre_reset_low", 32'(scl_out), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", 32'(obs_vec), 32'(7'b1000000));
    enable = 1'b0;
    repeat (2) @(negedge clk);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_idle", 32'(obs_vec), 32'(7'b1000000));

    // Randomized traffic against the model.
    stretch_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      next_cyc();
      if ($urandom_range(0, 39) == 0)  divisor = DW'($urandom_range(0, 12));
      if ($urandom_range(0, 149) == 0) stretch_en = ~stretch_en;
      if (!enable) begin
        if ($urandom_range(0, 2) == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
      end
      if (hold == 0 && tick_rise && stretch_en && $urandom_range(0, 1) == 1)
        hold = $urandom_range(1, 60);
      if (hold > 0) begin
        scl_in = 1'b0;
        hold--;
      end else begin
        scl_in = scl_out;
      end
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
